// File: rtl/gate_bist.sv
// Exhaustive truth-table walker for a combinational gate: drives every input
// vector, samples the gate output after a settle window and checks it.
module gate_bist #(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 4'b1110,
    parameter int                      SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [N_IN-1:0]            dut_in,
    input  logic                       dut_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [(1<<N_IN)-1:0]       captured,
    output logic [N_IN-1:0]            fail_index,
    output logic [N_IN:0]              err_count
);

    // state  | meaning
    // IDLE   | waiting for start; results of the last run held
    // HOLD   | current vector applied, settle counter running down
    // SAMPLE | gate output sampled and compared on the leaving edge
    // FIN    | done pulse, pass valid; returns to IDLE
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    localparam int               NV       = 1 << N_IN;
    localparam logic [N_IN-1:0]  LAST     = {N_IN{1'b1}};
    localparam logic [3:0]       SETTLE_L = 4'(SETTLE);

    logic [1:0]          state_q, state_d;
    logic [N_IN-1:0]     dut_in_q, dut_in_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [NV-1:0]       captured_q, captured_d;
    logic [N_IN-1:0]     fail_index_q, fail_index_d;
    logic [N_IN:0]       err_count_q, err_count_d;

    always_comb begin
        state_d      = state_q;
        dut_in_d     = dut_in_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        captured_d   = captured_q;
        fail_index_d = fail_index_q;
        err_count_d  = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_HOLD;
                    dut_in_d     = '0;
                    cnt_d        = SETTLE_L;
                    busy_d       = 1'b1;
                    captured_d   = '0;
                    err_count_d  = '0;
                    fail_index_d = '0;
                    pass_d       = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                captured_d[dut_in_q] = dut_out;
                if (dut_out != EXPECT[dut_in_q]) begin
                    err_count_d = err_count_q + (N_IN+1)'(1);
                    if (err_count_q == '0) begin
                        fail_index_d = dut_in_q;
                    end
                end
                // pass must reflect the final vector's sample, so it is
                // derived from the updated count rather than the flop
                if (dut_in_q == LAST) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    dut_in_d = dut_in_q + N_IN'(1);
                    cnt_d    = SETTLE_L;
                    state_d  = S_HOLD;
                end
            end
            S_FIN: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dut_in_q     <= '0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            captured_q   <= '0;
            fail_index_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            dut_in_q     <= dut_in_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            captured_q   <= captured_d;
            fail_index_q <= fail_index_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign captured   = captured_q;
    assign fail_index = fail_index_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: two instances (2-input OR, 3-input majority
// with a longer settle window) driven by table-defined gates.
module tb_gate_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start0, start1;
    logic [15:0] tbl0, tbl1;

    logic [1:0]  dut_in0;
    logic        dut_out0, busy0, done0, pass0;
    logic [3:0]  cap0;
    logic [1:0]  fidx0;
    logic [2:0]  err0;

    logic [2:0]  dut_in1;
    logic        dut_out1, busy1, done1, pass1;
    logic [7:0]  cap1;
    logic [2:0]  fidx1;
    logic [3:0]  err1;

    assign dut_out0 = tbl0[dut_in0];
    assign dut_out1 = tbl1[dut_in1];

    gate_bist #(.N_IN(2), .EXPECT(4'b1110), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(dut_in0),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .fail_index(fidx0), .err_count(err0)
    );

    gate_bist #(.N_IN(3), .EXPECT(8'b1110_1000), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .fail_index(fidx1), .err_count(err1)
    );

    logic [3:0]  din   [2];
    logic        busy_a[2];
    logic        done_a[2];
    logic        pass_a[2];
    logic [15:0] cap_a [2];
    logic [3:0]  fidx_a[2];
    logic [4:0]  err_a [2];

    assign din[0]    = {2'b00, dut_in0};
    assign din[1]    = {1'b0, dut_in1};
    assign busy_a[0] = busy0;
    assign busy_a[1] = busy1;
    assign done_a[0] = done0;
    assign done_a[1] = done1;
    assign pass_a[0] = pass0;
    assign pass_a[1] = pass1;
    assign cap_a[0]  = {12'b0, cap0};
    assign cap_a[1]  = {8'b0, cap1};
    assign fidx_a[0] = {2'b00, fidx0};
    assign fidx_a[1] = {1'b0, fidx1};
    assign err_a[0]  = {2'b00, err0};
    assign err_a[1]  = {1'b0, err1};

    typedef struct {
        int          start_cyc;
        logic [15:0] cap;
        int          errs;
        int          fidx;
        int          pass;
    } exp_t;

    exp_t sb[2][$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int nin(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int settle(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] exp_tbl(input int i);
        return (i == 0) ? 16'h000E : 16'h00E8;
    endfunction

    function automatic int run_len(input int i);
        return (1 << nin(i)) * (settle(i) + 2);
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp)
            $display("FAIL %s[%0d]: got %0d expected %0d (t=%0t)", nm, i, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic set_start(input int i, input logic v);
        if (i == 0) start0 = v; else start1 = v;
    endtask

    task automatic set_tbl(input int i, input logic [15:0] t);
        if (i == 0) tbl0 = t; else tbl1 = t;
    endtask

    // Reference: walk the truth table in ascending vector order.
    task automatic push_exp(input int i, input logic [15:0] t, input int s);
        exp_t        e;
        int          nv;
        logic [15:0] ex;
        nv = 1 << nin(i);
        ex = exp_tbl(i);
        e.start_cyc = s;
        e.cap  = '0;
        e.errs = 0;
        e.fidx = 0;
        for (int v = 0; v < nv; v++) begin
            e.cap[v] = t[v];
            if (t[v] != ex[v]) begin
                if (e.errs == 0) e.fidx = v;
                e.errs++;
            end
        end
        e.pass = (e.errs == 0) ? 1 : 0;
        sb[i].push_back(e);
    endtask

    // Monitor: per-cycle busy/dut_in/done timing and result compare at done.
    always @(negedge clk) begin : mon
        int L, j, sv, nv;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                L  = run_len(i);
                sv = settle(i);
                nv = 1 << nin(i);
                if (sb[i].size() != 0) begin
                    j = cyc - sb[i][0].start_cyc;
                    if (j < 0) begin
                        chk("busy_idle", i, int'(busy_a[i]), 0);
                        chk("done_idle", i, int'(done_a[i]), 0);
                    end else begin
                        chk("busy_run", i, int'(busy_a[i]), 1);
                        chk("dut_in", i, int'(din[i]), (j < L) ? j / (sv + 2) : nv - 1);
                        chk("done_time", i, int'(done_a[i]), (j == L) ? 1 : 0);
                        if (j >= L) begin
                            chk("captured", i, int'(cap_a[i]), int'(sb[i][0].cap));
                            chk("err_count", i, int'(err_a[i]), sb[i][0].errs);
                            chk("fail_index", i, int'(fidx_a[i]), sb[i][0].fidx);
                            chk("pass", i, int'(pass_a[i]), sb[i][0].pass);
                            void'(sb[i].pop_front());
                        end
                    end
                end else begin
                    chk("busy_quiet", i, int'(busy_a[i]), 0);
                    chk("done_quiet", i, int'(done_a[i]), 0);
                end
            end
        end
    end

    function automatic logic busy_of(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    task automatic run(input int i, input logic [15:0] t);
        int guard;
        guard = 0;
        while (busy_of(i) && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 500) chk("idle_timeout", i, guard, 0);
        @(negedge clk);
        set_tbl(i, t);
        set_start(i, 1'b1);
        @(posedge clk);
        #1;
        set_start(i, 1'b0);
        push_exp(i, t, cyc);
    endtask

    task automatic wait_empty(input int i);
        int guard;
        guard = 0;
        while (sb[i].size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            chk("done_timeout", i, guard, 0);
            sb[i].delete();
        end
    endtask

    task automatic chk_zero(input int i);
        chk("rst_dut_in", i, int'(din[i]), 0);
        chk("rst_busy", i, int'(busy_a[i]), 0);
        chk("rst_done", i, int'(done_a[i]), 0);
        chk("rst_pass", i, int'(pass_a[i]), 0);
        chk("rst_captured", i, int'(cap_a[i]), 0);
        chk("rst_fail_index", i, int'(fidx_a[i]), 0);
        chk("rst_err_count", i, int'(err_a[i]), 0);
    endtask

    initial begin
        logic [15:0] t;
        int          i, L0, s;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tbl0   = '0;
        tbl1   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed gates: OR, AND, stuck-at-1 on the 2-input unit;
        // majority and 3-input OR on the slow unit.
        run(0, 16'h000E); wait_empty(0);
        run(0, 16'h0008); wait_empty(0);
        run(0, 16'h000F); wait_empty(0);
        run(1, 16'h00E8); wait_empty(1);
        run(1, 16'h00FE); wait_empty(1);

        // Start re-pulsed mid-run must not restart or stretch the run.
        run(0, 16'h000E);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_empty(0);

        // Start held high across two runs: second begins the cycle after FIN.
        L0 = run_len(0);
        @(negedge clk);
        tbl0   = 16'h0006;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        push_exp(0, 16'h0006, s);
        push_exp(0, 16'h0006, s + L0 + 2);
        repeat (L0 + 2) @(posedge clk);
        #1 start0 = 1'b0;
        wait_empty(0);

        // Asynchronous reset in the middle of both runs.
        run(0, 16'h000E);
        run(1, 16'h00E8);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        sb[0].delete();
        sb[1].delete();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_done", 0, int'(done0), 0);
        chk("rst_hold_done", 1, int'(done1), 0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run(0, 16'h000E);
        run(1, 16'h00E8);
        wait_empty(0);
        wait_empty(1);

        // Randomized gate tables, often one bit off the expected table.
        for (int k = 0; k < 12; k++) begin
            i = k % 2;
            t = 16'($urandom) & 16'((1 << (1 << nin(i))) - 1);
            if ($urandom_range(0, 2) == 0)
                t = exp_tbl(i) ^ (16'd1 << $urandom_range(0, (1 << nin(i)) - 1));
            run(i, t);
        end
        wait_empty(0);
        wait_empty(1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
